// File: rtl/mem_arbiter_if.sv
// Bundle of fetch-port, data-port and RAM-side signals around the unified memory arbiter.
// The master modport is the arbiter's view; the slave modport is the CPU/RAM side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              iwait;
  logic [DATA_W-1:0] iload;

  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dwait;
  logic [DATA_W-1:0] dload;

  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic              ram_ready;

  logic              err;

  modport master (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );

  modport slave (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ram_ready,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, err
  );
endinterface

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port unified RAM between instruction fetch and data accesses,
// data-first with a streak limit, plus a per-access watchdog that latches a fatal error.
module mem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4,
  parameter int TIMEOUT     = 255
) (
  input  logic         CLK,
  input  logic         nRST,
  mem_arbiter_if.master bus
);

  localparam int SW = $clog2(MAX_DSTREAK + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_DSTREAK);
  localparam logic [WW-1:0] WDOG_MAX   = WW'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    IACC  = 2'd1,
    DACC  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic [WW-1:0] wdog_q, wdog_d;

  logic              dreq;
  logic              ren, wen;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] store;
  logic              iwait, dwait;
  logic [DATA_W-1:0] iload, dload;

  assign dreq = bus.dREN | bus.dWEN;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      streak_q <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      wdog_q   <= wdog_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    streak_d = streak_q;
    wdog_d   = wdog_q;
    ren      = 1'b0;
    wen      = 1'b0;
    addr     = '0;
    store    = '0;
    iwait    = bus.iREN;
    dwait    = dreq;
    iload    = '0;
    dload    = '0;

    unique case (state_q)
      IDLE: begin
        // Data wins unless it has already starved a pending fetch for the full streak.
        if (dreq && !(bus.iREN && (streak_q == STREAK_MAX))) begin
          state_d = DACC;
          wdog_d  = '0;
          if (!bus.iREN)
            streak_d = '0;
          else if (streak_q != STREAK_MAX)
            streak_d = streak_q + SW'(1);
        end else if (bus.iREN) begin
          state_d  = IACC;
          wdog_d   = '0;
          streak_d = '0;
        end
      end

      IACC: begin
        if (!bus.iREN) begin
          state_d = IDLE;
        end else begin
          ren  = 1'b1;
          addr = bus.iaddr;
          if (bus.ram_ready) begin
            iwait   = 1'b0;
            iload   = bus.ramload;
            state_d = IDLE;
          end else begin
            wdog_d = wdog_q + WW'(1);
            if (wdog_d == WDOG_MAX)
              state_d = ERROR;
          end
        end
      end

      DACC: begin
        if (!dreq) begin
          state_d = IDLE;
        end else begin
          addr = bus.daddr;
          // A write request overrides a simultaneous read request.
          if (bus.dWEN) begin
            wen   = 1'b1;
            store = bus.dstore;
          end else begin
            ren = 1'b1;
          end
          if (bus.ram_ready) begin
            dwait   = 1'b0;
            dload   = bus.ramload;
            state_d = IDLE;
          end else begin
            wdog_d = wdog_q + WW'(1);
            if (wdog_d == WDOG_MAX)
              state_d = ERROR;
          end
        end
      end

      ERROR: begin
        state_d = ERROR;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.ramREN   = ren;
  assign bus.ramWEN   = wen;
  assign bus.ramaddr  = addr;
  assign bus.ramstore = store;
  assign bus.iwait    = iwait;
  assign bus.dwait    = dwait;
  assign bus.iload    = iload;
  assign bus.dload    = dload;
  assign bus.err      = (state_q == ERROR);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a behavioural variable-latency RAM, a load-data
// scoreboard queue, and immediate assertions at every comparison point.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  mem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4), .TIMEOUT(8)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus)
  );

  // RAM model: completes on the lat-th consecutive enabled cycle, unless stalled.
  int unsigned lat   = 1;
  bit          stall = 1'b0;
  int unsigned rcnt  = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'd3) ^ 32'hC0DE_0000;
  endfunction

  assign bus.ram_ready = (bus.ramREN | bus.ramWEN) && !stall && (rcnt == lat - 1);
  assign bus.ramload   = memf(bus.ramaddr);

  always @(posedge CLK) begin
    if ((bus.ramREN | bus.ramWEN) && !bus.ram_ready) rcnt <= rcnt + 1;
    else rcnt <= 0;
  end

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  bit   expd[6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
  bit   found;
  int   cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] obs);
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=%0h expected=<scoreboard empty>", tag, obs);
    end else begin
      chk(tag, 64'(obs), 64'(sb.pop_front()));
    end
  endtask

  task automatic timeout_fail(input string tag);
    checks++;
    errors++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    bus.iREN = 1'b0; bus.iaddr = '0;
    bus.dREN = 1'b0; bus.dWEN = 1'b0; bus.daddr = '0; bus.dstore = '0;
    nRST = 1'b0;
    repeat (2) @(posedge CLK);
    smp();
    chk("rst_ramREN",   64'(bus.ramREN),   64'(0));
    chk("rst_ramWEN",   64'(bus.ramWEN),   64'(0));
    chk("rst_ramaddr",  64'(bus.ramaddr),  64'(0));
    chk("rst_ramstore", 64'(bus.ramstore), 64'(0));
    chk("rst_err",      64'(bus.err),      64'(0));
    chk("rst_iload",    64'(bus.iload),    64'(0));
    chk("rst_dload",    64'(bus.dload),    64'(0));
    bus.iREN = 1'b1; bus.dWEN = 1'b1; #1;
    chk("rst_iwait_follows", 64'(bus.iwait),  64'(1));
    chk("rst_dwait_follows", 64'(bus.dwait),  64'(1));
    chk("rst_no_grant",      64'(bus.ramREN | bus.ramWEN), 64'(0));
    bus.iREN = 1'b0; bus.dWEN = 1'b0;
    nxt(); nRST = 1'b1;

    // T1: single fetch, latency 2
    lat = 2; bus.iREN = 1'b1; bus.iaddr = 32'h40; sb.push_back(memf(32'h40));
    smp();
    chk("t1_c0_ramREN", 64'(bus.ramREN), 64'(0));
    chk("t1_c0_iwait",  64'(bus.iwait),  64'(1));
    nxt(); smp();
    chk("t1_c1_ramREN",  64'(bus.ramREN),  64'(1));
    chk("t1_c1_ramaddr", 64'(bus.ramaddr), 64'(32'h40));
    chk("t1_c1_iwait",   64'(bus.iwait),   64'(1));
    chk("t1_c1_iload0",  64'(bus.iload),   64'(0));
    nxt(); smp();
    chk("t1_c2_iwait", 64'(bus.iwait), 64'(0));
    pop_chk("t1_c2_iload", bus.iload);
    nxt(); bus.iREN = 1'b0; smp();
    chk("t1_c3_idle", 64'(bus.ramREN | bus.ramWEN), 64'(0));

    // T2: simultaneous fetch and data read, data goes first
    nxt(); lat = 1;
    bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h100;
    sb.push_back(memf(32'h100)); sb.push_back(memf(32'h44));
    smp();
    chk("t2_c0_ramREN", 64'(bus.ramREN), 64'(0));
    nxt(); smp();
    chk("t2_c1_ramaddr", 64'(bus.ramaddr), 64'(32'h100));
    chk("t2_c1_dwait",   64'(bus.dwait),   64'(0));
    chk("t2_c1_iwait",   64'(bus.iwait),   64'(1));
    chk("t2_c1_iload0",  64'(bus.iload),   64'(0));
    pop_chk("t2_c1_dload", bus.dload);
    nxt(); bus.dREN = 1'b0; smp();
    chk("t2_c2_idle",  64'(bus.ramREN), 64'(0));
    chk("t2_c2_iwait", 64'(bus.iwait),  64'(1));
    nxt(); smp();
    chk("t2_c3_ramaddr", 64'(bus.ramaddr), 64'(32'h44));
    chk("t2_c3_iwait",   64'(bus.iwait),   64'(0));
    pop_chk("t2_c3_iload", bus.iload);
    nxt(); bus.iREN = 1'b0;

    // T3: streak limit, grants D D D D I D
    nxt();
    bus.iREN = 1'b1; bus.iaddr = 32'h48; bus.dREN = 1'b1; bus.daddr = 32'h200;
    for (int g = 0; g < 6; g++) begin
      sb.push_back(expd[g] ? memf(32'h200) : memf(32'h48));
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
        smp();
        if (bus.ramREN) begin
          found = 1'b1;
          chk($sformatf("t3_grant%0d_isD", g), 64'(bus.ramaddr == 32'h200), 64'(expd[g]));
          if (expd[g]) begin
            chk($sformatf("t3_grant%0d_dwait", g), 64'(bus.dwait), 64'(0));
            chk($sformatf("t3_grant%0d_iwait", g), 64'(bus.iwait), 64'(1));
            pop_chk($sformatf("t3_grant%0d_dload", g), bus.dload);
          end else begin
            chk($sformatf("t3_grant%0d_iwait", g), 64'(bus.iwait), 64'(0));
            chk($sformatf("t3_grant%0d_dwait", g), 64'(bus.dwait), 64'(1));
            pop_chk($sformatf("t3_grant%0d_iload", g), bus.iload);
          end
        end
        nxt();
      end
      if (!found) timeout_fail($sformatf("t3_grant%0d", g));
    end
    bus.iREN = 1'b0; bus.dREN = 1'b0;

    // T4: writes, and write precedence over read
    nxt(); bus.dWEN = 1'b1; bus.daddr = 32'h80; bus.dstore = 32'hDEADBEEF;
    smp();
    chk("t4_c0_ramWEN", 64'(bus.ramWEN), 64'(0));
    nxt(); smp();
    chk("t4_c1_ramWEN",   64'(bus.ramWEN),   64'(1));
    chk("t4_c1_ramREN",   64'(bus.ramREN),   64'(0));
    chk("t4_c1_ramaddr",  64'(bus.ramaddr),  64'(32'h80));
    chk("t4_c1_ramstore", 64'(bus.ramstore), 64'(32'hDEADBEEF));
    chk("t4_c1_dwait",    64'(bus.dwait),    64'(0));
    nxt(); bus.dWEN = 1'b0; smp();
    chk("t4_c2_ramstore0", 64'(bus.ramstore), 64'(0));
    nxt(); bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h84; bus.dstore = 32'h12345678;
    smp(); nxt(); smp();
    chk("t4_rw_ramWEN",   64'(bus.ramWEN),   64'(1));
    chk("t4_rw_ramREN",   64'(bus.ramREN),   64'(0));
    chk("t4_rw_ramstore", 64'(bus.ramstore), 64'(32'h12345678));
    chk("t4_rw_dwait",    64'(bus.dwait),    64'(0));
    nxt(); bus.dREN = 1'b0; bus.dWEN = 1'b0;

    // T5: RAM never ready -> ERROR after TIMEOUT cycles, cleared only by reset
    nxt(); stall = 1'b1; bus.iREN = 1'b1; bus.iaddr = 32'h60;
    cnt = 0; found = 1'b0;
    for (int k = 0; k < 30 && !found; k++) begin
      smp();
      if (bus.err) found = 1'b1;
      else begin
        if (bus.ramREN) cnt++;
        nxt();
      end
    end
    if (!found) timeout_fail("t5_err_rise");
    chk("t5_iacc_cycles", 64'(cnt),        64'(8));
    chk("t5_err",         64'(bus.err),    64'(1));
    chk("t5_ramREN",      64'(bus.ramREN), 64'(0));
    chk("t5_iwait",       64'(bus.iwait),  64'(1));
    stall = 1'b0;
    repeat (3) nxt();
    smp();
    chk("t5_err_sticky",    64'(bus.err),    64'(1));
    chk("t5_ramREN_sticky", 64'(bus.ramREN), 64'(0));
    nxt(); nRST = 1'b0; #1;
    chk("t5_rst_err", 64'(bus.err), 64'(0));
    nxt(); nRST = 1'b1; smp();
    chk("t5_post_idle", 64'(bus.ramREN), 64'(0));
    sb.push_back(memf(32'h60));
    nxt(); smp();
    chk("t5_regrant_ramaddr", 64'(bus.ramaddr), 64'(32'h60));
    chk("t5_regrant_iwait",   64'(bus.iwait),   64'(0));
    pop_chk("t5_regrant_iload", bus.iload);
    nxt(); bus.iREN = 1'b0;

    // T6: asynchronous reset in the middle of a data access
    nxt(); lat = 4; bus.dREN = 1'b1; bus.daddr = 32'h300; sb.push_back(memf(32'h300));
    smp(); nxt(); smp();
    chk("t6_c1_ramREN", 64'(bus.ramREN), 64'(1));
    chk("t6_c1_dwait",  64'(bus.dwait),  64'(1));
    nxt(); #2; nRST = 1'b0; #1;
    chk("t6_async_ramREN", 64'(bus.ramREN), 64'(0));
    chk("t6_async_ramWEN", 64'(bus.ramWEN), 64'(0));
    chk("t6_async_dwait",  64'(bus.dwait),  64'(1));
    nxt(); nRST = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      smp();
      if (!bus.dwait) begin
        found = 1'b1;
        pop_chk("t6_regrant_dload", bus.dload);
      end else nxt();
    end
    if (!found) timeout_fail("t6_regrant");
    nxt(); bus.dREN = 1'b0;

    // T7: fetch withdrawn mid-access
    nxt(); bus.iREN = 1'b1; bus.iaddr = 32'h70;
    smp(); nxt(); smp();
    chk("t7_c1_ramREN", 64'(bus.ramREN), 64'(1));
    nxt(); bus.iREN = 1'b0; smp();
    chk("t7_abandon_ramREN", 64'(bus.ramREN), 64'(0));
    chk("t7_abandon_iload",  64'(bus.iload),  64'(0));
    nxt(); smp();
    chk("t7_idle", 64'(bus.ramREN | bus.ramWEN), 64'(0));
    chk("t7_sb_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
